// File: rtl/veerwolf_wb_pkg.sv
// rtl/veerwolf_wb_pkg.sv - shared Wishbone initiator types and constants
package veerwolf_wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    // Response status, also consumed by debug bridges layered on this initiator
    typedef enum logic [1:0] {
        WB_RSP_OK      = 2'd0,
        WB_RSP_TIMEOUT = 2'd1,
        WB_RSP_BUSERR  = 2'd2
    } wb_status_e;

endpackage

// File: rtl/veerwolf_wb_watchdog.sv
// rtl/veerwolf_wb_watchdog.sv - loadable down-counter that flags a non-responding slave
module veerwolf_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_run,
    output logic o_expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = CW'(TIMEOUT);
        end else if (i_run && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the edge on which the count reaches 0, i.e. after TIMEOUT running cycles
    assign o_expired = (TIMEOUT != 0) && i_run && (count_q == CW'(1));

endmodule

// File: rtl/veerwolf_wb_initiator.sv
// rtl/veerwolf_wb_initiator.sv - single-access Wishbone classic initiator; WB_INITIATOR_ERR_EN adds i_wb_err
module veerwolf_wb_initiator
    import veerwolf_wb_pkg::*;
#(
    parameter int AW      = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [AW-1:0]    i_cmd_adr,
    input  logic [WB_DW-1:0] i_cmd_dat,
    input  logic [WB_SW-1:0] i_cmd_sel,
    input  logic             i_cmd_we,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WB_DW-1:0] o_rsp_dat,
    output logic             o_rsp_err,
    output logic [AW-1:0]    o_wb_adr,
    output logic [WB_DW-1:0] o_wb_dat,
    output logic [WB_SW-1:0] o_wb_sel,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_wb_stb,
    input  logic [WB_DW-1:0] i_wb_rdt,
`ifdef WB_INITIATOR_ERR_EN
    input  logic             i_wb_err,
`endif
    input  logic             i_wb_ack
);

    wb_state_e        state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [WB_DW-1:0] dat_q, dat_d;
    logic [WB_SW-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WB_DW-1:0] rsp_dat_q, rsp_dat_d;
    wb_status_e       status_q, status_d;
    logic             wd_load;
    logic             wd_expired;
    logic             bus_err;

`ifdef WB_INITIATOR_ERR_EN
    assign bus_err = i_wb_err;
`else
    assign bus_err = 1'b0;
`endif

    veerwolf_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (wd_load),
        .i_run     (state_q == ST_BUS),
        .o_expired (wd_expired)
    );

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        status_d    = status_q;
        wd_load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    adr_d   = i_cmd_adr;
                    dat_d   = i_cmd_dat;
                    sel_d   = i_cmd_sel;
                    we_d    = i_cmd_we;
                    cyc_d   = 1'b1;
                    wd_load = 1'b1;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Priority err > ack > expiry: a terminated cycle never reports timeout
                if (bus_err) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    status_d    = WB_RSP_BUSERR;
                    state_d     = ST_RESP;
                end else if (i_wb_ack) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = we_q ? '0 : i_wb_rdt;
                    status_d    = WB_RSP_OK;
                    state_d     = ST_RESP;
                end else if (wd_expired) begin
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    status_d    = WB_RSP_TIMEOUT;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            status_q    <= WB_RSP_OK;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            status_q    <= status_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE) && !i_rst;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;
    assign o_wb_we     = we_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = (status_q != WB_RSP_OK);

endmodule

// File: tb/tb_veerwolf_wb_initiator.sv
// tb/tb_veerwolf_wb_initiator.sv - self-checking bench for veerwolf_wb_initiator
module tb_veerwolf_wb_initiator;

    localparam int AW = 6;
    localparam int TO = 8;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_adr = '0;
    logic [31:0]   i_cmd_dat = '0;
    logic [3:0]    i_cmd_sel = '0;
    logic          i_cmd_we = 1'b0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [31:0]   o_rsp_dat;
    logic          o_rsp_err;
    logic [AW-1:0] o_wb_adr;
    logic [31:0]   o_wb_dat;
    logic [3:0]    o_wb_sel;
    logic          o_wb_we;
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic [31:0]   i_wb_rdt = '0;
    logic          i_wb_ack = 1'b0;
    logic          i_wb_err = 1'b0;
    logic          drive_err = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc_n;
        int          valid_at;
        logic [31:0] dat;
        logic        err;
        int          unstable;
        int          ready_viol;
        int          bp_cycles;
        logic        ready_after;
        logic        valid_after;
        bit          done;
    } obs_t;

    veerwolf_wb_initiator #(.AW(AW), .TIMEOUT(TO)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_adr   (i_cmd_adr),
        .i_cmd_dat   (i_cmd_dat),
        .i_cmd_sel   (i_cmd_sel),
        .i_cmd_we    (i_cmd_we),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_dat   (o_rsp_dat),
        .o_rsp_err   (o_rsp_err),
        .o_wb_adr    (o_wb_adr),
        .o_wb_dat    (o_wb_dat),
        .o_wb_sel    (o_wb_sel),
        .o_wb_we     (o_wb_we),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .i_wb_rdt    (i_wb_rdt),
`ifdef WB_INITIATOR_ERR_EN
        .i_wb_err    (i_wb_err),
`endif
        .i_wb_ack    (i_wb_ack)
    );

    always #5 i_clk = ~i_clk;

    // Reference: an access terminates on the ack cycle if it comes within TO cycles of cyc, else times out
    function automatic void model(input logic we, input logic [31:0] rdt, input int ack_at,
                                  input logic err_on, output int cyc_n, output logic [31:0] dat,
                                  output logic err);
        bit acked;
        acked = (ack_at >= 1) && (ack_at <= TO);
        cyc_n = acked ? ack_at : TO;
        err   = !acked || (acked && err_on);
        dat   = (acked && !err_on && !we) ? rdt : 32'h0;
    endfunction

    // Drives one command; ack_at = cycle of cyc (1-based) on which the slave acks, 0 = never
    task automatic run_access(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [31:0] rdt, input int ack_at,
                              input int rdy_delay, output obs_t o);
        int n;
        int waited;
        o.cyc_n = 0; o.valid_at = -1; o.dat = '0; o.err = 1'b0; o.unstable = 0;
        o.ready_viol = 0; o.bp_cycles = 0; o.ready_after = 1'b0; o.valid_after = 1'b1; o.done = 0;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_adr = adr; i_cmd_dat = dat; i_cmd_sel = sel;
        i_rsp_ready = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0; i_cmd_we = ~we; i_cmd_adr = AW'($urandom);
        i_cmd_dat = $urandom; i_cmd_sel = 4'($urandom);
        n = 0;
        waited = 0;
        while (!o.done && n < 200) begin
            @(negedge i_clk);
            n++;
            if (o_wb_cyc !== o_wb_stb) o.unstable++;
            if (o_wb_cyc === 1'b1) begin
                o.cyc_n++;
                if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== {adr, dat, sel, we}) o.unstable++;
            end
            i_wb_ack = (o_wb_cyc === 1'b1) ? (n == ack_at) : 1'($urandom);
            i_wb_err = (o_wb_cyc === 1'b1) && (n == ack_at) && drive_err;
            i_wb_rdt = ((o_wb_cyc === 1'b1) && (n == ack_at)) ? rdt : $urandom;
            if (o_rsp_valid === 1'b1) begin
                if (o.valid_at < 0) begin
                    o.valid_at = n - 1;
                    o.dat = o_rsp_dat;
                    o.err = o_rsp_err;
                end else if (o_rsp_dat !== o.dat || o_rsp_err !== o.err) begin
                    o.unstable++;
                end
                if (o_cmd_ready !== 1'b0) o.ready_viol++;
                if (waited >= rdy_delay) begin
                    i_rsp_ready = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_rsp_ready = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
                    o.done = 1;
                end else begin
                    waited++;
                    o.bp_cycles++;
                end
            end
        end
        @(negedge i_clk);
        o.ready_after = o_cmd_ready;
        o.valid_after = o_rsp_valid;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_wb_cyc, o_wb_stb, o_rsp_valid, o_rsp_err, o_cmd_ready} !== 5'b0 ||
            o_rsp_dat !== 32'h0 || {o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== '0) begin
            failures++;
            $display("FAIL reset_state: cyc=%b stb=%b valid=%b err=%b ready=%b dat=%h adr=%h wdat=%h sel=%h we=%b, required all 0",
                     o_wb_cyc, o_wb_stb, o_rsp_valid, o_rsp_err, o_cmd_ready, o_rsp_dat,
                     o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b, required 1", o_cmd_ready);
        end
    endtask

    task automatic test_read;
        obs_t o;
        run_access(1'b0, 6'h3C, 32'h1234_5678, 4'hF, 32'hCAFE0001, 2, 0, o);
        checks++;
        if (o.cyc_n != 2 || o.valid_at != 2) begin
            failures++;
            $display("FAIL read_latency: cyc=%0d valid_at=%0d, required cyc=2 valid_at=2", o.cyc_n, o.valid_at);
        end
        checks++;
        if (o.dat !== 32'hCAFE0001 || o.err !== 1'b0 || !o.done) begin
            failures++;
            $display("FAIL read_data: dat=%h err=%b done=%0d, required dat=cafe0001 err=0 done=1", o.dat, o.err, o.done);
        end
    endtask

    task automatic test_write;
        obs_t o;
        run_access(1'b1, 6'h10, 32'h0000_00A5, 4'b0001, 32'hDEAD_BEEF, 2, 0, o);
        checks++;
        if (o.unstable != 0 || o.cyc_n != 2) begin
            failures++;
            $display("FAIL write_bus: unstable=%0d cyc=%0d, required unstable=0 cyc=2", o.unstable, o.cyc_n);
        end
        checks++;
        if (o.dat !== 32'h0 || o.err !== 1'b0 || o.valid_at != 2) begin
            failures++;
            $display("FAIL write_rsp: dat=%h err=%b valid_at=%0d, required dat=0 err=0 valid_at=2", o.dat, o.err, o.valid_at);
        end
    endtask

    task automatic test_timeout;
        obs_t o;
        run_access(1'b0, 6'h21, 32'h0, 4'hF, 32'h5555_AAAA, 0, 0, o);
        checks++;
        if (o.cyc_n != TO || o.err !== 1'b1 || o.dat !== 32'h0 || !o.done) begin
            failures++;
            $display("FAIL timeout: cyc=%0d err=%b dat=%h done=%0d, required cyc=%0d err=1 dat=0 done=1",
                     o.cyc_n, o.err, o.dat, o.done, TO);
        end
        run_access(1'b0, 6'h22, 32'h0, 4'hF, 32'h0BAD_F00D, 1, 0, o);
        checks++;
        if (o.dat !== 32'h0BAD_F00D || o.err !== 1'b0 || o.cyc_n != 1) begin
            failures++;
            $display("FAIL after_timeout: dat=%h err=%b cyc=%0d, required dat=0badf00d err=0 cyc=1", o.dat, o.err, o.cyc_n);
        end
    endtask

    task automatic test_ack_at_expiry;
        obs_t o;
        run_access(1'b0, 6'h05, 32'h0, 4'hF, 32'h7777_0008, TO, 0, o);
        checks++;
        if (o.err !== 1'b0 || o.dat !== 32'h7777_0008 || o.cyc_n != TO) begin
            failures++;
            $display("FAIL ack_at_expiry: err=%b dat=%h cyc=%0d, required err=0 dat=77770008 cyc=%0d", o.err, o.dat, o.cyc_n, TO);
        end
    endtask

    task automatic test_backpressure;
        obs_t o;
        run_access(1'b0, 6'h2A, 32'h0, 4'h3, 32'h0F0F_0F0F, 3, 5, o);
        checks++;
        if (o.unstable != 0 || o.ready_viol != 0 || o.bp_cycles != 5) begin
            failures++;
            $display("FAIL backpressure_hold: unstable=%0d ready_viol=%0d bp=%0d, required 0 0 5",
                     o.unstable, o.ready_viol, o.bp_cycles);
        end
        checks++;
        if (o.ready_after !== 1'b1 || o.valid_after !== 1'b0 || o.dat !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL backpressure_release: ready=%b valid=%b dat=%h, required ready=1 valid=0 dat=0f0f0f0f",
                     o.ready_after, o.valid_after, o.dat);
        end
    endtask

    task automatic test_reset_mid_bus;
        int bad;
        @(negedge i_clk);
        i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_adr = 6'h0A; i_cmd_sel = 4'hF; i_wb_ack = 1'b0;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_bus: cyc=%b stb=%b valid=%b, required 0 0 0", o_wb_cyc, o_wb_stb, o_rsp_valid);
        end
        i_rst = 1'b0;
        bad = 0;
        repeat (12) begin
            @(negedge i_clk);
            i_wb_ack = 1'($urandom);
            if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_wb_cyc !== 1'b0) bad++;
        end
        i_wb_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_mid_bus_after: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_bus_err;
        obs_t o;
        drive_err = 1'b1;
        run_access(1'b0, 6'h11, 32'h0, 4'hF, 32'h1111_2222, 2, 0, o);
        drive_err = 1'b0;
        checks++;
        if (o.err !== 1'b1 || o.dat !== 32'h0 || o.cyc_n != 2) begin
            failures++;
            $display("FAIL bus_err: err=%b dat=%h cyc=%0d, required err=1 dat=0 cyc=2", o.err, o.dat, o.cyc_n);
        end
    endtask

    task automatic test_random;
        obs_t        o;
        logic        we;
        logic [31:0] rdt;
        int          ack_at;
        int          exp_cyc;
        logic [31:0] exp_dat;
        logic        exp_err;
        for (int i = 0; i < 30; i++) begin
            we     = 1'($urandom);
            rdt    = $urandom;
            ack_at = $urandom_range(0, TO + 3);
            model(we, rdt, ack_at, 1'b0, exp_cyc, exp_dat, exp_err);
            run_access(we, AW'($urandom), $urandom, 4'($urandom), rdt, ack_at, $urandom_range(0, 4), o);
            checks++;
            if (!o.done || o.cyc_n != exp_cyc || o.valid_at != exp_cyc || o.dat !== exp_dat || o.err !== exp_err) begin
                failures++;
                $display("FAIL random_%0d: done=%0d cyc=%0d valid_at=%0d dat=%h err=%b, required cyc=%0d valid_at=%0d dat=%h err=%b",
                         i, o.done, o.cyc_n, o.valid_at, o.dat, o.err, exp_cyc, exp_cyc, exp_dat, exp_err);
            end
            checks++;
            if (o.unstable != 0 || o.ready_viol != 0 || o.ready_after !== 1'b1 || o.valid_after !== 1'b0) begin
                failures++;
                $display("FAIL random_proto_%0d: unstable=%0d ready_viol=%0d ready_after=%b valid_after=%b, required 0 0 1 0",
                         i, o.unstable, o.ready_viol, o.ready_after, o.valid_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_ack_at_expiry();
        test_backpressure();
        test_reset_mid_bus();
`ifdef WB_INITIATOR_ERR_EN
        test_bus_err();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
